hv_lbist_mc: RTL
================

HV_LBIST_MC -- requirements
Module: hv_lbist_mc

Interface
REQ-001 Parameter SCAN_REG_NUM, default 8, number of scan registers checked in the scan phase (>=1).
REQ-002 Parameter OWT_CH_NUM, default 2, number of independent OWT receive channels (>=1).
REQ-003 Parameter OWT_RX_OK_NUM, default 4, good frames required per channel for pass (>=1).
REQ-004 Parameter BIST_TMO_TH, default 1024, OWT observation window length in cycles (>=2).
REQ-005 Parameter SCAN_ACK_TMO, default 16, max cycles waiting for one scan ack (>=2).
REQ-006 i_clk  input  1  single clock, all logic on rising edge.
REQ-007 i_rst_n  input  1  reset, synchronous, active-low.
REQ-008 i_bist_en  input  1  level run enable; deassertion aborts.
REQ-009 i_bist_mode  input  2  bit0 scan phase enable, bit1 OWT phase enable.
REQ-010 o_bist_scan_reg_req  output  1  scan check request.
REQ-011 o_bist_scan_reg_idx  output  SIDX_W=max(1,$clog2(SCAN_REG_NUM))  index under test.
REQ-012 i_scan_reg_bist_ack  input  1  scan check complete.
REQ-013 i_scan_reg_bist_err  input  1  scan check failed, valid with ack.
REQ-014 i_owt_rx_ack  input  OWT_CH_NUM  per-channel frame received.
REQ-015 i_owt_rx_status  input  OWT_CH_NUM  per-channel frame status, 1=error, valid with ack.
REQ-016 o_hv_scan_bist_rult  output  1  scan fail, 1=fail.
REQ-017 o_hv_scan_err_idx  output  SIDX_W  first failing scan index.
REQ-018 o_hv_owt_bist_rult  output  OWT_CH_NUM  per-channel OWT fail, 1=fail.
REQ-019 o_hv_bist_busy  output  1  high in SCAN or OWT state.
REQ-020 o_hv_bist_done  output  1  level, high in DONE state.

Function
REQ-021 FSM states IDLE, SCAN, OWT, DONE; i_bist_mode sampled on IDLE exit only.
REQ-022 IDLE with i_bist_en=1: next state SCAN if mode[0], else OWT if mode[1], else DONE (mode 00 = immediate pass).
REQ-023 SCAN: req asserted with idx starting at 0; req held until ack or ack timeout; req low the cycle after; next idx req one cycle later (one-cycle gap).
REQ-024 Ack while req low ignored; per-request wait counter reaching SCAN_ACK_TMO-1 without ack counts as a failure for that idx.
REQ-025 Failure (ack&err or timeout) sets sticky o_hv_scan_bist_rult; o_hv_scan_err_idx captured on first failure only.
REQ-026 After idx SCAN_REG_NUM-1 completes: next state OWT if mode[1], else DONE.
REQ-027 OWT: window counter counts 0..BIST_TMO_TH-1; per-channel ok counter, width $clog2(OWT_RX_OK_NUM+1), increments on ack&~status, saturates at OWT_RX_OK_NUM.
REQ-028 Ack arriving on window cycle BIST_TMO_TH-1 ignored; simultaneous acks on several channels all counted.
REQ-029 Window end: o_hv_owt_bist_rult[ch]=(ok_cnt[ch]<OWT_RX_OK_NUM), then DONE.
REQ-030 DONE holds all results until i_bist_en=0, then IDLE.
REQ-031 i_bist_en=0 in any state: IDLE next cycle, all counters and results cleared, req low, done never asserted for aborted run.
REQ-032 IDLE outputs: req=0, idx=0, all rult=0, err_idx=0, busy=0, done=0.

Reset
REQ-033 i_rst_n=0 at a rising edge forces IDLE and REQ-032 values, overriding all other inputs, including mid-run.
REQ-034 No asynchronous reset path.

Configuration
REQ-035 Macro HV_LBIST_SCAN_RETRY_EN defined: a failing idx is re-requested once (after one-cycle gap); failure recorded only if retry also fails.
REQ-036 Macro undefined: first failure is final, no retry logic present.

Verification
REQ-037 Defaults, mode=11, all scan acks err=0 in 3 cycles, 4 good frames per channel -> scan rult=0, owt rult=00, done after scan + 1024 window cycles.
REQ-038 Mode=01, idx 5 ack with err=1, idx 6 no ack -> rult=1, err_idx=5, idx 6 advances after 16 wait cycles, OWT skipped.
REQ-039 Mode=10, ch0 4 good frames, ch1 3 good + 2 error frames, one ch0 ack on last window cycle -> owt rult=10.
REQ-040 Drop i_bist_en mid-SCAN at idx 3, then reassert -> IDLE, outputs cleared, restart at idx 0, no done pulse.
REQ-041 With HV_LBIST_SCAN_RETRY_EN, idx 2 fails once then passes -> rult=0; fails twice -> rult=1, err_idx=2; without macro single fail -> rult=1.

Source files
------------

// File: rtl/hv_lbist_mc_if.sv
// hv_lbist_mc_if - run control, scan-check handshake, OWT receive and result
// signals of the HV logic-BIST controller.
// master: controller view; slave: environment view (host, scan chain, OWT receivers).
interface hv_lbist_mc_if #(
  parameter int SCAN_REG_NUM = 8,
  parameter int OWT_CH_NUM   = 2
);
  localparam int SIDX_W = (SCAN_REG_NUM > 1) ? $clog2(SCAN_REG_NUM) : 1;

  logic                  i_bist_en;
  logic [1:0]            i_bist_mode;
  logic                  o_bist_scan_reg_req;
  logic [SIDX_W-1:0]     o_bist_scan_reg_idx;
  logic                  i_scan_reg_bist_ack;
  logic                  i_scan_reg_bist_err;
  logic [OWT_CH_NUM-1:0] i_owt_rx_ack;
  logic [OWT_CH_NUM-1:0] i_owt_rx_status;
  logic                  o_hv_scan_bist_rult;
  logic [SIDX_W-1:0]     o_hv_scan_err_idx;
  logic [OWT_CH_NUM-1:0] o_hv_owt_bist_rult;
  logic                  o_hv_bist_busy;
  logic                  o_hv_bist_done;

  modport master (
    input  i_bist_en, i_bist_mode, i_scan_reg_bist_ack, i_scan_reg_bist_err,
           i_owt_rx_ack, i_owt_rx_status,
    output o_bist_scan_reg_req, o_bist_scan_reg_idx, o_hv_scan_bist_rult,
           o_hv_scan_err_idx, o_hv_owt_bist_rult, o_hv_bist_busy, o_hv_bist_done
  );

  modport slave (
    output i_bist_en, i_bist_mode, i_scan_reg_bist_ack, i_scan_reg_bist_err,
           i_owt_rx_ack, i_owt_rx_status,
    input  o_bist_scan_reg_req, o_bist_scan_reg_idx, o_hv_scan_bist_rult,
           o_hv_scan_err_idx, o_hv_owt_bist_rult, o_hv_bist_busy, o_hv_bist_done
  );
endinterface

// File: rtl/hv_lbist_mc.sv
// hv_lbist_mc - HV logic-BIST master controller.
// Runs an optional scan-register check phase followed by an optional OWT
// frame-observation window, then holds pass/fail results until the run
// enable drops. Dropping the enable aborts and clears everything.
// Build option: define HV_LBIST_SCAN_RETRY_EN to re-request a failing scan
// index once and record the failure only if the retry also fails.
module hv_lbist_mc #(
  parameter int SCAN_REG_NUM  = 8,
  parameter int OWT_CH_NUM    = 2,
  parameter int OWT_RX_OK_NUM = 4,
  parameter int BIST_TMO_TH   = 1024,
  parameter int SCAN_ACK_TMO  = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  hv_lbist_mc_if.master bus
);
  localparam int SIDX_W = (SCAN_REG_NUM > 1) ? $clog2(SCAN_REG_NUM) : 1;
  localparam int TW     = $clog2(SCAN_ACK_TMO);
  localparam int WW     = $clog2(BIST_TMO_TH);
  localparam int OKW    = $clog2(OWT_RX_OK_NUM + 1);

  localparam logic [SIDX_W-1:0] IDX_LAST = SIDX_W'(SCAN_REG_NUM - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(SCAN_ACK_TMO - 1);
  localparam logic [WW-1:0]     WIN_LAST = WW'(BIST_TMO_TH - 1);
  localparam logic [OKW-1:0]    OK_TH    = OKW'(OWT_RX_OK_NUM);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OWT, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic                  owt_en_q, owt_en_d;
  logic                  req_q, req_d;
  logic [SIDX_W-1:0]     idx_q, idx_d;
  logic [TW-1:0]         swait_q, swait_d;
  logic                  scan_rult_q, scan_rult_d;
  logic [SIDX_W-1:0]     err_idx_q, err_idx_d;
  logic [WW-1:0]         win_q, win_d;
  logic [OKW-1:0]        ok_cnt_q [OWT_CH_NUM];
  logic [OKW-1:0]        ok_cnt_d [OWT_CH_NUM];
  logic [OWT_CH_NUM-1:0] owt_rult_q, owt_rult_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef HV_LBIST_SCAN_RETRY_EN
  logic                  retry_q, retry_d;
`endif
  logic                  req_done;
  logic                  fail;
  logic                  fin;

  // Next-state and next-output logic for the whole controller
  always_comb begin
    state_d     = state_q;
    owt_en_d    = owt_en_q;
    req_d       = req_q;
    idx_d       = idx_q;
    swait_d     = swait_q;
    scan_rult_d = scan_rult_q;
    err_idx_d   = err_idx_q;
    win_d       = win_q;
    ok_cnt_d    = ok_cnt_q;
    owt_rult_d  = owt_rult_q;
`ifdef HV_LBIST_SCAN_RETRY_EN
    retry_d     = retry_q;
`endif
    req_done    = 1'b0;
    fail        = 1'b0;
    fin         = 1'b0;
    if (!bus.i_bist_en) begin
      // Abort or idle: everything returns to its cleared value
      state_d     = ST_IDLE;
      owt_en_d    = 1'b0;
      req_d       = 1'b0;
      idx_d       = '0;
      swait_d     = '0;
      scan_rult_d = 1'b0;
      err_idx_d   = '0;
      win_d       = '0;
      owt_rult_d  = '0;
      for (int c = 0; c < OWT_CH_NUM; c++) ok_cnt_d[c] = '0;
`ifdef HV_LBIST_SCAN_RETRY_EN
      retry_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Mode is only looked at here; later changes do not affect the run
          owt_en_d = bus.i_bist_mode[1];
          if (bus.i_bist_mode[0]) begin
            state_d = ST_SCAN;
            req_d   = 1'b1;
          end else if (bus.i_bist_mode[1]) begin
            state_d = ST_OWT;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_SCAN: begin
          if (req_q) begin
            req_done = bus.i_scan_reg_bist_ack || (swait_q == TMO_LAST);
            fail     = bus.i_scan_reg_bist_ack ? bus.i_scan_reg_bist_err : 1'b1;
            if (req_done) begin
              req_d   = 1'b0;
              swait_d = '0;
`ifdef HV_LBIST_SCAN_RETRY_EN
              if (fail && !retry_q) begin
                retry_d = 1'b1;
              end else begin
                retry_d = 1'b0;
                fin     = 1'b1;
              end
`else
              fin = 1'b1;
`endif
            end else begin
              swait_d = swait_q + TW'(1);
            end
          end else begin
            // One-cycle gap: re-issue the same index on retry, else the next one
            req_d = 1'b1;
`ifdef HV_LBIST_SCAN_RETRY_EN
            if (!retry_q) idx_d = idx_q + SIDX_W'(1);
`else
            idx_d = idx_q + SIDX_W'(1);
`endif
          end
          if (fin) begin
            if (fail && !scan_rult_q) begin
              scan_rult_d = 1'b1;
              err_idx_d   = idx_q;
            end
            if (idx_q == IDX_LAST) state_d = owt_en_q ? ST_OWT : ST_DONE;
          end
        end
        ST_OWT: begin
          if (win_q == WIN_LAST) begin
            // Acks on the final window cycle are deliberately not counted
            for (int c = 0; c < OWT_CH_NUM; c++) owt_rult_d[c] = (ok_cnt_q[c] < OK_TH);
            state_d = ST_DONE;
          end else begin
            win_d = win_q + WW'(1);
            for (int c = 0; c < OWT_CH_NUM; c++) begin
              if (bus.i_owt_rx_ack[c] && !bus.i_owt_rx_status[c] && (ok_cnt_q[c] < OK_TH))
                ok_cnt_d[c] = ok_cnt_q[c] + OKW'(1);
            end
          end
        end
        ST_DONE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_SCAN) || (state_d == ST_OWT);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      owt_en_q    <= 1'b0;
      req_q       <= 1'b0;
      idx_q       <= '0;
      swait_q     <= '0;
      scan_rult_q <= 1'b0;
      err_idx_q   <= '0;
      win_q       <= '0;
      for (int c = 0; c < OWT_CH_NUM; c++) ok_cnt_q[c] <= '0;
      owt_rult_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef HV_LBIST_SCAN_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owt_en_q    <= owt_en_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      swait_q     <= swait_d;
      scan_rult_q <= scan_rult_d;
      err_idx_q   <= err_idx_d;
      win_q       <= win_d;
      ok_cnt_q    <= ok_cnt_d;
      owt_rult_q  <= owt_rult_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef HV_LBIST_SCAN_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.o_bist_scan_reg_req = req_q;
  assign bus.o_bist_scan_reg_idx = idx_q;
  assign bus.o_hv_scan_bist_rult = scan_rult_q;
  assign bus.o_hv_scan_err_idx   = err_idx_q;
  assign bus.o_hv_owt_bist_rult  = owt_rult_q;
  assign bus.o_hv_bist_busy      = busy_q;
  assign bus.o_hv_bist_done      = done_q;
endmodule
